// File: rtl/fpu_pkg.sv
// Shared types for the FP issue scheduler: FSM states and the pending-op record.
package fpu_pkg;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_t;

  localparam int FREG_W = 5;
  localparam int PEND_W = FREG_W + 1;

  typedef struct packed {
    logic [FREG_W-1:0] fd;
    logic              we;
  } pend_t;

endpackage

// File: rtl/fpu_pending_fifo.sv
// In-order record of launched FP ops; head is combinational, push/pop/flush take effect next edge.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module fpu_pending_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [PEND_W-1:0]       push_dat,
  output logic [PEND_W-1:0]       head_dat,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  pend_t          mem [DEPTH];
  logic  [AW-1:0] wr_ptr;
  logic  [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= pend_t'(push_dat);
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fpu_issue_sched.sv
// In-order FP issue scheduler: RAW/WAW scoreboard, long-op serialisation, writeback steering, timeout abort.
// issue_ready/fpu_start/wb_* are same-cycle combinational; all bookkeeping updates on the next edge.
module fpu_issue_sched
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [2:0]             issue_fs_use,
  input  logic [4:0]             issue_fs1,
  input  logic [4:0]             issue_fs2,
  input  logic [4:0]             issue_fs3,
  input  logic [4:0]             issue_fd,
  input  logic                   issue_fd_we,
  input  logic                   issue_long,
  output logic                   fpu_start,
  input  logic                   fpu_complete,
  output logic                   wb_en,
  output logic [4:0]             wb_addr,
  output logic                   halt_req,
  output logic [$clog2(DEPTH):0] pending_cnt,
  output logic                   timeout_err,
  output logic                   spurious_err,
  input  logic                   err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t          state, state_n;
  logic [31:0]     sb, sb_n;
  logic            long_active, long_active_n;
  logic [TW-1:0]   tmo_cnt;
  logic [PEND_W-1:0] head_dat;
  pend_t           head;
  logic            hazard, accept, complete, q_empty, running;
  logic            tmo_inc, to_err;

  fpu_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pop      (complete),
    .flush    (to_err),
    .push_dat ({issue_fd, issue_fd_we}),
    .head_dat (head_dat),
    .count    (pending_cnt)
  );

  assign head    = pend_t'(head_dat);
  assign running = (state == RUN);
  assign q_empty = (pending_cnt == '0);

  // Registered scoreboard only: a completing producer releases its consumer one cycle later.
  assign hazard = (issue_fs_use[0] & sb[issue_fs1]) |
                  (issue_fs_use[1] & sb[issue_fs2]) |
                  (issue_fs_use[2] & sb[issue_fs3]) |
                  (issue_fd_we     & sb[issue_fd]);

  // Gating with rst keeps every output low while reset is held.
  assign issue_ready = ~rst & running & ~hazard & (pending_cnt < CW'(DEPTH)) &
                       ~long_active & ~(issue_long & ~q_empty);
  assign accept      = issue_valid & issue_ready;
  assign complete    = ~rst & running & fpu_complete & ~q_empty;

  assign fpu_start = accept;
  assign wb_en     = complete & head.we;
  assign wb_addr   = complete ? head.fd : '0;
  assign halt_req  = long_active & running;

  assign tmo_inc = running & ~q_empty & ~complete & ~accept;
  assign to_err  = tmo_inc & (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (to_err)  state_n = ERR;
      ERR:     if (err_clr) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Set after clear so a same-cycle retire/reissue of one fd leaves the bit pending.
  always_comb begin
    sb_n          = sb;
    long_active_n = long_active;
    if (complete && head.we)    sb_n[head.fd] = 1'b0;
    if (complete)               long_active_n = 1'b0;
    if (accept && issue_fd_we)  sb_n[issue_fd] = 1'b1;
    if (accept && issue_long)   long_active_n = 1'b1;
    if (to_err) begin
      sb_n          = '0;
      long_active_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      sb           <= '0;
      long_active  <= 1'b0;
      tmo_cnt      <= '0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      state       <= state_n;
      sb          <= sb_n;
      long_active <= long_active_n;
      tmo_cnt     <= tmo_inc ? tmo_cnt + 1'b1 : '0;

      if (to_err)                      timeout_err <= 1'b1;
      else if (!running && err_clr)    timeout_err <= 1'b0;

      if (running && fpu_complete && q_empty) spurious_err <= 1'b1;
      else if (err_clr)                       spurious_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed self-checking bench for fpu_issue_sched (DEPTH=4, TIMEOUT=8).
module tb_fpu_issue_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] issue_fs_use;
  logic [4:0] issue_fs1, issue_fs2, issue_fs3, issue_fd;
  logic       issue_fd_we, issue_long;
  logic       fpu_start, fpu_complete;
  logic       wb_en;
  logic [4:0] wb_addr;
  logic       halt_req;
  logic [2:0] pending_cnt;
  logic       timeout_err, spurious_err, err_clr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fpu_issue_sched #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_fs_use (issue_fs_use),
    .issue_fs1    (issue_fs1),
    .issue_fs2    (issue_fs2),
    .issue_fs3    (issue_fs3),
    .issue_fd     (issue_fd),
    .issue_fd_we  (issue_fd_we),
    .issue_long   (issue_long),
    .fpu_start    (fpu_start),
    .fpu_complete (fpu_complete),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .halt_req     (halt_req),
    .pending_cnt  (pending_cnt),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err),
    .err_clr      (err_clr)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid  = 1'b0;
    issue_fs_use = 3'b000;
    issue_fs1    = 5'd0;
    issue_fs2    = 5'd0;
    issue_fs3    = 5'd0;
    issue_fd     = 5'd0;
    issue_fd_we  = 1'b0;
    issue_long   = 1'b0;
    fpu_complete = 1'b0;
    err_clr      = 1'b0;
  endtask

  task automatic offer(input logic v, input logic [2:0] use_m, input logic [4:0] f1,
                       input logic [4:0] fd, input logic we, input logic lng);
    issue_valid  = v;
    issue_fs_use = use_m;
    issue_fs1    = f1;
    issue_fd     = fd;
    issue_fd_we  = we;
    issue_long   = lng;
  endtask

  task automatic test_reset;
    idle();
    rst          = 1'b1;
    issue_valid  = 1'b1;
    fpu_complete = 1'b1;
    #12;
    total++;
    if ({issue_ready, fpu_start, wb_en, wb_addr, halt_req, pending_cnt, timeout_err, spurious_err} !== 14'd0)
      $display("FAIL reset_outputs got=%b exp=0", {issue_ready, fpu_start, wb_en, wb_addr, halt_req,
               pending_cnt, timeout_err, spurious_err});
    else passed++;
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (issue_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", issue_ready);
    else passed++;
  endtask

  task automatic test_independent;
    logic [4:0] exp_fd;
    for (int i = 1; i <= 4; i++) begin
      exp_fd = 5'(i);
      offer(1'b1, 3'b000, 5'd0, exp_fd, 1'b1, 1'b0);
      #1;
      total++;
      if ({issue_ready, fpu_start} !== 2'b11)
        $display("FAIL indep_accept%0d got=%b exp=11", i, {issue_ready, fpu_start});
      else passed++;
      cyc();
    end
    offer(1'b1, 3'b000, 5'd0, 5'd5, 1'b1, 1'b0);
    #1;
    total++;
    if (pending_cnt !== 3'd4) $display("FAIL indep_cnt got=%0d exp=4", pending_cnt);
    else passed++;
    total++;
    if (issue_ready !== 1'b0) $display("FAIL indep_full_ready got=%b exp=0", issue_ready);
    else passed++;
    issue_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_fd = 5'(i);
      fpu_complete = 1'b1;
      #1;
      total++;
      if ({wb_en, wb_addr} !== {1'b1, exp_fd})
        $display("FAIL indep_wb%0d got=%b/%0d exp=1/%0d", i, wb_en, wb_addr, exp_fd);
      else passed++;
      cyc();
    end
    fpu_complete = 1'b0;
    #1;
    total++;
    if (pending_cnt !== 3'd0) $display("FAIL indep_drained got=%0d exp=0", pending_cnt);
    else passed++;
  endtask

  task automatic test_raw;
    offer(1'b1, 3'b000, 5'd0, 5'd5, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 3'b001, 5'd5, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (issue_ready !== 1'b0) $display("FAIL raw_stall%0d got=%b exp=0", i, issue_ready);
      else passed++;
      cyc();
    end
    fpu_complete = 1'b1;
    #1;
    total++;
    if ({wb_en, wb_addr} !== {1'b1, 5'd5}) $display("FAIL raw_wb got=%b/%0d exp=1/5", wb_en, wb_addr);
    else passed++;
    total++;
    if (issue_ready !== 1'b0) $display("FAIL raw_no_bypass got=%b exp=0", issue_ready);
    else passed++;
    cyc();
    fpu_complete = 1'b0;
    #1;
    total++;
    if (issue_ready !== 1'b1) $display("FAIL raw_release got=%b exp=1", issue_ready);
    else passed++;
    cyc();
    issue_valid  = 1'b0;
    fpu_complete = 1'b1;
    #1;
    total++;
    if ({wb_en, wb_addr} !== {1'b1, 5'd6}) $display("FAIL raw_wb_dep got=%b/%0d exp=1/6", wb_en, wb_addr);
    else passed++;
    cyc();
    idle();
  endtask

  task automatic test_long;
    offer(1'b1, 3'b000, 5'd0, 5'd7, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 3'b000, 5'd0, 5'd8, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 3'b000, 5'd0, 5'd9, 1'b1, 1'b1);
    #1;
    total++;
    if (issue_ready !== 1'b0) $display("FAIL long_wait2 got=%b exp=0", issue_ready);
    else passed++;
    fpu_complete = 1'b1;
    cyc();
    total++;
    if (issue_ready !== 1'b0) $display("FAIL long_wait1 got=%b exp=0", issue_ready);
    else passed++;
    cyc();
    fpu_complete = 1'b0;
    #1;
    total++;
    if ({issue_ready, halt_req} !== 2'b10) $display("FAIL long_accept got=%b exp=10", {issue_ready, halt_req});
    else passed++;
    cyc();
    offer(1'b1, 3'b000, 5'd0, 5'd10, 1'b1, 1'b0);
    #1;
    total++;
    if (halt_req !== 1'b1) $display("FAIL long_halt got=%b exp=1", halt_req);
    else passed++;
    total++;
    if (issue_ready !== 1'b0) $display("FAIL long_block got=%b exp=0", issue_ready);
    else passed++;
    cyc();
    issue_valid  = 1'b0;
    fpu_complete = 1'b1;
    #1;
    total++;
    if ({wb_en, wb_addr} !== {1'b1, 5'd9}) $display("FAIL long_wb got=%b/%0d exp=1/9", wb_en, wb_addr);
    else passed++;
    cyc();
    fpu_complete = 1'b0;
    #1;
    total++;
    if (halt_req !== 1'b0) $display("FAIL long_halt_fall got=%b exp=0", halt_req);
    else passed++;
    idle();
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_fd;
    for (int i = 11; i <= 13; i++) begin
      offer(1'b1, 3'b000, 5'd0, 5'(i), 1'b1, 1'b0);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      exp_fd = 5'(11 + k);
      offer(1'b1, 3'b000, 5'd0, 5'(14 + k), 1'b1, 1'b0);
      fpu_complete = 1'b1;
      #1;
      total++;
      if ({issue_ready, wb_en, wb_addr} !== {2'b11, exp_fd})
        $display("FAIL b2b_swap%0d got=%b/%b/%0d exp=1/1/%0d", k, issue_ready, wb_en, wb_addr, exp_fd);
      else passed++;
      cyc();
      total++;
      if (pending_cnt !== 3'd3) $display("FAIL b2b_cnt%0d got=%0d exp=3", k, pending_cnt);
      else passed++;
    end
    fpu_complete = 1'b0;
    offer(1'b1, 3'b000, 5'd0, 5'd17, 1'b1, 1'b0);
    cyc();
    issue_valid = 1'b0;
    #1;
    total++;
    if ({pending_cnt, issue_ready} !== {3'd4, 1'b0})
      $display("FAIL b2b_full got=%0d/%b exp=4/0", pending_cnt, issue_ready);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      exp_fd = 5'(14 + k);
      fpu_complete = 1'b1;
      #1;
      total++;
      if ({wb_en, wb_addr} !== {1'b1, exp_fd})
        $display("FAIL b2b_wrap%0d got=%b/%0d exp=1/%0d", k, wb_en, wb_addr, exp_fd);
      else passed++;
      cyc();
    end
    idle();
  endtask

  task automatic test_timeout;
    offer(1'b1, 3'b000, 5'd0, 5'd20, 1'b1, 1'b1);
    #1;
    total++;
    if (issue_ready !== 1'b1) $display("FAIL tmo_accept got=%b exp=1", issue_ready);
    else passed++;
    cyc();
    issue_valid = 1'b0;
    total++;
    if (halt_req !== 1'b1) $display("FAIL tmo_halt got=%b exp=1", halt_req);
    else passed++;
    repeat (7) cyc();
    total++;
    if ({timeout_err, pending_cnt} !== {1'b0, 3'd1})
      $display("FAIL tmo_early got=%b/%0d exp=0/1", timeout_err, pending_cnt);
    else passed++;
    cyc();
    total++;
    if ({timeout_err, halt_req, pending_cnt, issue_ready} !== {1'b1, 1'b0, 3'd0, 1'b0})
      $display("FAIL tmo_abort got=%b/%b/%0d/%b exp=1/0/0/0", timeout_err, halt_req, pending_cnt, issue_ready);
    else passed++;
    fpu_complete = 1'b1;
    cyc();
    fpu_complete = 1'b0;
    total++;
    if ({timeout_err, spurious_err, wb_en} !== 3'b100)
      $display("FAIL tmo_ignore_cmp got=%b exp=100", {timeout_err, spurious_err, wb_en});
    else passed++;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    offer(1'b0, 3'b001, 5'd20, 5'd21, 1'b1, 1'b0);
    #1;
    total++;
    if ({timeout_err, issue_ready} !== 2'b01)
      $display("FAIL tmo_clear got=%b exp=01", {timeout_err, issue_ready});
    else passed++;
    idle();
  endtask

  task automatic test_spurious_and_reset;
    fpu_complete = 1'b1;
    #1;
    total++;
    if (wb_en !== 1'b0) $display("FAIL spur_wb got=%b exp=0", wb_en);
    else passed++;
    cyc();
    fpu_complete = 1'b0;
    total++;
    if (spurious_err !== 1'b1) $display("FAIL spur_set got=%b exp=1", spurious_err);
    else passed++;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    total++;
    if (spurious_err !== 1'b0) $display("FAIL spur_clr got=%b exp=0", spurious_err);
    else passed++;
    offer(1'b1, 3'b000, 5'd0, 5'd21, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 3'b000, 5'd0, 5'd22, 1'b1, 1'b1);
    offer(1'b1, 3'b000, 5'd0, 5'd22, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 3'b000, 5'd0, 5'd23, 1'b1, 1'b0);
    fpu_complete = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({issue_ready, fpu_start, wb_en, wb_addr, halt_req, pending_cnt, timeout_err, spurious_err} !== 14'd0)
      $display("FAIL rst_async got=%b exp=0", {issue_ready, fpu_start, wb_en, wb_addr, halt_req,
               pending_cnt, timeout_err, spurious_err});
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    offer(1'b0, 3'b001, 5'd21, 5'd24, 1'b1, 1'b0);
    #1;
    total++;
    if ({pending_cnt, issue_ready} !== {3'd0, 1'b1})
      $display("FAIL rst_flushed got=%0d/%b exp=0/1", pending_cnt, issue_ready);
    else passed++;
    idle();
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_long();
    test_back_to_back();
    test_timeout();
    test_spurious_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1);
  end

endmodule
